// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared types and constants for the serial-bus arbiter slice
package serial_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;
  localparam int NUM_MASTERS = 2;
  localparam int M1_IDX = 0;
  localparam int M2_IDX = 1;
endpackage

// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if: request/split/grant bundle; master = requesters and slaves, slave = arbiter
interface serial_bus_arbiter_if #(
  parameter int NUM_SLAVES = 3,
  parameter int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) ();
  logic [1:0] m_req;
  logic split_req;
  logic [SLV_W-1:0] split_slv_id;
  logic [NUM_SLAVES-1:0] s_split_rdy;
  logic [1:0] m_grant;
  logic [1:0] m_split;
  logic bus_owner;
  logic bus_idle;
  logic hold_timeout;
  modport master (
    output m_req, split_req, split_slv_id, s_split_rdy,
    input m_grant, m_split, bus_owner, bus_idle, hold_timeout
  );
  modport slave (
    input m_req, split_req, split_slv_id, s_split_rdy,
    output m_grant, m_split, bus_owner, bus_idle, hold_timeout
  );
endinterface

// File: rtl/arb_split_tracker.sv
// arb_split_tracker: per-master parked flag, splitting-slave tag and latched resume flag
// ports: clock, rst; i_park/i_clr per-master strobes; i_slv_id slave tag; i_s_split_rdy per-slave ready pulses; o_m_split parked vector; o_resumable
module arb_split_tracker import serial_bus_pkg::*; #(
  parameter int NUM_SLAVES = 3,
  parameter int SLV_W = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic [NUM_MASTERS-1:0] i_park,
  input  logic [NUM_MASTERS-1:0] i_clr,
  input  logic [SLV_W-1:0] i_slv_id,
  input  logic [NUM_SLAVES-1:0] i_s_split_rdy,
  output logic [NUM_MASTERS-1:0] o_m_split,
  output logic [NUM_MASTERS-1:0] o_resumable
);
  logic [SLV_W-1:0] r_tag [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] r_split, r_rdy, w_hit;
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      w_hit[i] = r_split[i] && (int'(r_tag[i]) < NUM_SLAVES) && i_s_split_rdy[r_tag[i]];
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      r_split <= '0;
      r_rdy <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_tag[i] <= '0;
    end else begin
      r_split <= i_park | (r_split & ~i_clr);
      r_rdy <= ~(i_park | i_clr) & (r_rdy | w_hit);
      for (int i = 0; i < NUM_MASTERS; i++) r_tag[i] <= i_park[i] ? i_slv_id : r_tag[i];
    end
  end
  assign o_m_split = r_split;
  assign o_resumable = r_split & r_rdy;
endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: two-master bus arbiter with split/resume and hold watchdog
// ports: clock, rst (sync, active high); bus (slave modport): m_req, split_req, split_slv_id, s_split_rdy in; m_grant, m_split, bus_owner, bus_idle, hold_timeout out (registered)
// ARB_ROUND_ROBIN_EN selects round-robin among normal requesters, otherwise fixed M1-first priority
module serial_bus_arbiter import serial_bus_pkg::*; #(
  parameter int NUM_SLAVES = 3,
  parameter int MAX_HOLD = 20000
) (
  input logic clock,
  input logic rst,
  serial_bus_arbiter_if.slave bus
);
  localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  arb_state_t r_state;
  logic r_owner, r_to;
  logic [CW-1:0] r_hold_cnt;
  logic [NUM_MASTERS-1:0] r_blk;
  logic [NUM_MASTERS-1:0] w_split, w_resumable, w_norm, w_park, w_clr;
  logic w_any, w_pick, w_win, w_own_req, w_split_ev, w_to, w_grant_ev;
  arb_split_tracker #(.NUM_SLAVES(NUM_SLAVES), .SLV_W(SLV_W)) u_trk (
    .clock(clock),
    .rst(rst),
    .i_park(w_park),
    .i_clr(w_clr),
    .i_slv_id(bus.split_slv_id),
    .i_s_split_rdy(bus.s_split_rdy),
    .o_m_split(w_split),
    .o_resumable(w_resumable)
  );
`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;
  always_ff @(posedge clock) r_ptr <= rst ? 1'b0 : (w_grant_ev ? !w_win : r_ptr);
  assign w_pick = (&w_norm) ? r_ptr : w_norm[M2_IDX];
`else
  assign w_pick = !w_norm[M1_IDX];
`endif
  // r_blk keeps a timed-out master out of arbitration until it drops m_req
  always_comb begin
    w_norm = bus.m_req & ~w_split & ~r_blk;
    w_any = |(w_norm | w_resumable);
    w_win = w_resumable[M1_IDX] ? 1'b0 : (w_resumable[M2_IDX] ? 1'b1 : w_pick);
    w_own_req = bus.m_req[r_owner];
    w_split_ev = (r_state == GRANT) && bus.split_req;
    w_to = (MAX_HOLD != 0) && (r_state == GRANT) && !bus.split_req && w_own_req && (int'(r_hold_cnt) + 1 == MAX_HOLD);
    w_grant_ev = (r_state == IDLE) && w_any;
    w_park = w_split_ev ? (2'b01 << r_owner) : 2'b00;
    w_clr = w_grant_ev ? (w_resumable & (2'b01 << w_win)) : 2'b00;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_hold_cnt <= '0;
      r_blk <= '0;
      r_to <= 1'b0;
    end else begin
      r_state <= (r_state == IDLE) ? (w_any ? GRANT : IDLE) :
                 (r_state == GRANT) ? ((w_split_ev || !w_own_req || w_to) ? TURN : GRANT) : IDLE;
      r_owner <= w_grant_ev ? w_win : r_owner;
      r_hold_cnt <= (r_state != GRANT) ? '0 : ((r_hold_cnt == CW'(MAX_HOLD)) ? r_hold_cnt : r_hold_cnt + 1'b1);
      r_blk <= (r_blk & bus.m_req) | (w_to ? (2'b01 << r_owner) : 2'b00);
      r_to <= w_to;
    end
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      bus.m_grant <= '0;
      bus.m_split <= '0;
      bus.bus_owner <= 1'b0;
      bus.bus_idle <= 1'b1;
      bus.hold_timeout <= 1'b0;
    end else begin
      bus.m_grant <= (r_state == GRANT) ? (2'b01 << r_owner) : 2'b00;
      bus.m_split <= w_split;
      bus.bus_owner <= r_owner;
      bus.bus_idle <= r_state != GRANT;
      bus.hold_timeout <= r_to;
    end
  end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: vector-table bench with expected-output scoreboard
module tb_serial_bus_arbiter;
  typedef struct {
    logic rst_v;
    logic [1:0] req;
    logic spl;
    logic [1:0] id;
    logic [2:0] rdy;
    logic [1:0] g;
    logic [1:0] s;
    logic t;
  } vec_t;
  logic clock = 1'b0;
  logic rst = 1'b1;
  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  serial_bus_arbiter_if #(.NUM_SLAVES(3)) bus ();
  serial_bus_arbiter #(.NUM_SLAVES(3), .MAX_HOLD(8)) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic add(input int n, input logic rst_v, input logic [1:0] req, input logic spl,
                     input logic [1:0] id, input logic [2:0] rdy, input logic [1:0] g,
                     input logic [1:0] s, input logic t);
    vec_t v;
    v = '{rst_v, req, spl, id, rdy, g, s, t};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask
  task automatic chk(input string nm, input int row, input logic [1:0] act, input logic [1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", nm, row, act, exp_v);
    end
  endtask
  initial begin
    bit rr;
    logic [1:0] w, wd;
    vec_t e;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    w = rr ? 2'b10 : 2'b01;
    wd = rr ? 2'b01 : 2'b10;
    // single request, release and idle gap
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b00, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(2, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    // contention: fixed priority or round robin
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(5, 0, 2'b11, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(5, 0, 2'b11, 0, 0, 3'b000, w, 2'b00, 0);
    add(1, 0, wd, 0, 0, 3'b000, w, 2'b00, 0);
    add(1, 0, wd, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    // split M1 on slave 2, M2 takes bus, resume M1 first
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b11, 1, 2, 3'b000, 2'b01, 2'b00, 0);
    add(2, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b01, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b10, 2'b01, 0);
    add(1, 0, 2'b11, 0, 0, 3'b100, 2'b10, 2'b01, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b10, 2'b01, 0);
    add(2, 0, 2'b11, 0, 0, 3'b000, 2'b00, 2'b01, 0);
    add(1, 0, 2'b11, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    // ready from the wrong slave is ignored, right slave resumes
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b01, 1, 2, 3'b000, 2'b01, 2'b00, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 0, 0, 3'b010, 2'b00, 2'b01, 0);
    add(2, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 0, 0, 3'b100, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b01, 2'b00, 0);
    // watchdog at MAX_HOLD = 8, re-grant only after req toggles
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(8, 0, 2'b10, 0, 0, 3'b000, 2'b10, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 1);
    add(3, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b10, 2'b00, 0);
    // reset with M2 parked discards split state
    add(1, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b10, 2'b00, 0);
    add(1, 0, 2'b10, 1, 0, 3'b000, 2'b10, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b10, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b10, 0);
    add(1, 0, 2'b01, 0, 0, 3'b000, 2'b01, 2'b10, 0);
    add(1, 1, 2'b01, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 0, 0, 3'b000, 2'b10, 2'b00, 0);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      rst = vecs[k].rst_v;
      bus.m_req = vecs[k].req;
      bus.split_req = vecs[k].spl;
      bus.split_slv_id = vecs[k].id;
      bus.s_split_rdy = vecs[k].rdy;
      sb.push_back(vecs[k]);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("m_grant", k, bus.m_grant, e.g);
      chk("m_split", k, bus.m_split, e.s);
      chk("bus_idle", k, {1'b0, bus.bus_idle}, {1'b0, e.g == 2'b00});
      chk("hold_timeout", k, {1'b0, bus.hold_timeout}, {1'b0, e.t});
      if (e.g != 2'b00) chk("bus_owner", k, {1'b0, bus.bus_owner}, {1'b0, e.g[1]});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

- Grants one of the two serial-bus masters (M1 index 0, M2 index 1) ownership of the shared bus.
- Supports split transactions: a slave can park the current owner, and the owner is re-granted with top priority once that slave is ready.
- Includes a hold watchdog against runaway owners.
- Sits between the master request lines and the bus mux select in the serial-bus top level.

## Interface
Parameters:
- NUM_SLAVES, 3, number of slaves that may issue split; slave id width SLV_W = $clog2(NUM_SLAVES)
- MAX_HOLD, 20000, max consecutive grant cycles before forced release; 0 disables watchdog

Ports:
- clock  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  2  per-master request; held high for the whole transaction (including bursts)
- split_req  in  1  current slave splits the owner's transaction; 1-cycle pulse
- split_slv_id  in  SLV_W  id of the splitting slave; valid with split_req
- s_split_rdy  in  NUM_SLAVES  per-slave pulse: split data ready; parked master may resume
- m_grant  out  2  one-hot grant, or 0
- m_split  out  2  master parked on a split
- bus_owner  out  1  index of granted master; valid when m_grant != 0
- bus_idle  out  1  no grant asserted
- hold_timeout  out  1  1-cycle pulse on watchdog release

## Operation
- FSM states and transitions:
  - IDLE: decide winner from the current inputs -> GRANT.
  - GRANT: hold grant while owner's m_req = 1 -> on release, split or timeout -> TURN.
  - TURN: exactly one turnaround cycle with m_grant = 0 -> IDLE.
- Eligibility:
  - Master i is eligible if m_req[i] = 1 and m_split[i] = 0, or if it is resumable.
  - Resumable means m_split[i] = 1 and the recorded slave for i has pulsed s_split_rdy. The pulse is latched in a per-master resume flag.
- Priority order:
  1. Resumable masters, lowest index first.
  2. Normal requesters per the arbitration policy (see Configuration).
- Split handling:
  - split_req in GRANT sets m_split[owner] and records split_slv_id in slv_tag[owner].
  - Grant drops next cycle.
  - The parked master's m_req is ignored until it is resumed.
- Resume:
  - The grant to a resumable master clears its m_split and resume flag on the same edge.
  - The resumed master is then expected to hold m_req.
- Edge cases:
  - s_split_rdy for a slave with no parked master is ignored.
  - If both masters are parked on the same slave id, one rdy pulse resumes both; M1 is granted first.
- Watchdog:
  - hold_cnt counts GRANT cycles.
  - When hold_cnt reaches MAX_HOLD: force TURN, pulse hold_timeout, leave m_split unchanged.
  - After a forced release, the owner must drop m_req for ≥1 cycle before it is eligible again.
- Simultaneous events:
  - split_req together with the owner's m_req falling: split wins (master parked).
  - split_req together with the timeout: split wins, no hold_timeout.
  - split_req outside GRANT is ignored.

## Timing
- Reset values:
  - m_grant = 0, m_split = 0, bus_owner = 0, bus_idle = 1, hold_timeout = 0.
  - FSM = IDLE; hold_cnt, slv_tag, resume flags and the round-robin pointer cleared.
- Reset mid-transaction drops the grant on the next edge and discards all parked state.
- Grant latency: m_req sampled high in IDLE at edge N -> m_grant high after edge N+1.
- Release: owner m_req low at edge N -> m_grant low after N+1 -> TURN -> earliest new grant after N+3.
- Split: split_req at edge N -> m_grant low and m_split set after N+1.
- Resume: s_split_rdy at edge N -> earliest re-grant after N+2 if the FSM is in IDLE.
- Outputs are registered; no combinational path from inputs to outputs.
- hold_cnt width is $clog2(MAX_HOLD+1); it saturates and never wraps.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Among normal requesters, the master not granted last wins when both request.
  - The pointer updates on every grant, including resumes.
- Not defined: fixed priority; M1 always wins over M2; no pointer register exists.

## Structure
- Shared package serial_bus_pkg holds:
  - arb_state_t enum (IDLE, GRANT, TURN)
  - NUM_MASTERS = 2
  - master index constants M1_IDX = 0, M2_IDX = 1
- One sub-module: arb_split_tracker.
  - Holds the per-master m_split, slv_tag and resume flags.
  - Inputs: park and clear strobes, slave id, s_split_rdy.
  - Outputs: m_split and the resumable vector.
- The FSM, watchdog and priority logic live in the top of the block.

## Test plan
- Reset, then m_req=2'b01 -> m_grant=2'b01 two edges later; drop req -> grant 0, bus_idle=1 for ≥2 cycles.
- m_req=2'b11 held, each master drops req after 5 grant cycles:
  - With ARB_ROUND_ROBIN_EN: grants alternate 01,10,01.
  - Without: 01 every time while M1 requests.
- M1 granted, split_req with split_slv_id=2:
  - m_split=01, grant moves to requesting M2.
  - s_split_rdy[2] pulse while M2 is owner: after M2 releases, M1 is granted before any new M2 request; m_split returns to 00.
- s_split_rdy[1] while only M1 is parked on slave 2 -> no effect; m_split stays 01.
- MAX_HOLD=8, M2 holds req -> hold_timeout pulses after 8 grant cycles; grant 0; no re-grant until M2 toggles req.
- rst during GRANT with M2 parked -> all outputs return to reset values next edge; M2's later request is a normal arbitration.
